conv_window_gen: RTL



---
 rtl/conv_window_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers, a 3x3 register window and one output register.
// Define CONV_WINDOW_FLAGS_EN to add the out_sof / out_eol window flags.
module conv_window_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_CHANNELS = 9,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 64
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [IN_CHANNELS*DATA_WIDTH-1:0]   in_pixel,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [9*IN_CHANNELS*DATA_WIDTH-1:0] out_window,
    output logic                                frame_done
`ifdef CONV_WINDOW_FLAGS_EN
    ,
    output logic                                out_sof,
    output logic                                out_eol
`endif
);
    localparam int PW = IN_CHANNELS * DATA_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [PW-1:0]   lb0 [IMG_WIDTH];
    logic [PW-1:0]   lb1 [IMG_WIDTH];
    logic [PW-1:0]   win [9];
    logic [PW-1:0]   win_next [9];
    logic [9*PW-1:0] win_flat;
    logic            accept;
    logic            emit;
    logic            col_wrap;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = (row >= ROW_TWO) && (col >= COL_TWO);
    assign col_wrap = (col == COL_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_next = win;
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[r*3+0] = win[r*3+1];
            win_next[r*3+1] = win[r*3+2];
        end
        win_next[2] = lb1[col];
        win_next[5] = lb0[col];
        win_next[8] = in_pixel;
        for (int j = 0; j < 9; j++) begin
            win_flat[j*PW +: PW] = win_next[j];
        end
    end

    // NOTE: line-buffer RAM is deliberately left unreset so it can map to block RAM;
    // stale entries are overwritten before any window that could use them is emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pixel;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col        <= '0;
            row        <= '0;
            win        <= '{default: '0};
            out_valid  <= 1'b0;
            out_window <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                win <= win_next;
                if (col_wrap) begin
                    col        <= '0;
                    row        <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    frame_done <= (row == ROW_LAST);
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && emit) begin
                out_valid  <= 1'b1;
                out_window <= win_flat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WINDOW_FLAGS_EN
    // Flags follow out_window, so they are held under backpressure just like the taps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_sof <= 1'b0;
            out_eol <= 1'b0;
        end else if (accept && emit) begin
            out_sof <= (row == ROW_TWO) && (col == COL_TWO);
            out_eol <= col_wrap;
        end
    end
`endif

endmodule
